// File: rtl/mc_pad_selftest.sv
// Pad-ring loopback self-test: passes functional IO through when idle, otherwise
// drives one pad at a time with 0 then 1 and checks the synchronized readback.
module mc_pad_selftest #(
  parameter int NumPads      = 8,
  parameter int SettleCycles = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [NumPads-1:0] fail_mask_o,
  input  logic [NumPads-1:0] func_d_i,
  input  logic [NumPads-1:0] func_oe_i,
  output logic [NumPads-1:0] pad_d_o,
  output logic [NumPads-1:0] pad_oe_o,
  input  logic [NumPads-1:0] pad_d_i
);

  localparam int IdxW = (NumPads > 1) ? $clog2(NumPads) : 1;
  localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPads - 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               pat_q, pat_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NumPads-1:0] fail_q, fail_d;
  logic               pass_q, pass_d;
  logic [NumPads-1:0] sync1_q, sync2_q;
  logic               busy;

  // pad_d_i is asynchronous to clk_i; two flops before anyone looks at it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_d_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= 1'b0;
      cnt_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // Handshake: start_i is a request taken only in IDLE (no queuing); done_o is a
  // single-cycle completion strobe, after which pass_o/fail_mask_o stay valid
  // until the next accepted start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    busy    = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          pat_d   = 1'b0;
          cnt_d   = CntLoad;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      SAMPLE: begin
        busy = 1'b1;
        fail_d[idx_q] = fail_q[idx_q] | (sync2_q[idx_q] != pat_q);
        if (!pat_q) begin
          pat_d   = 1'b1;
          cnt_d   = CntLoad;
          state_d = SETTLE;
        end else if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          pat_d   = 1'b0;
          cnt_d   = CntLoad;
          state_d = SETTLE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        pass_d  = (fail_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While testing only the pad under test drives; the rest are released.
  always_comb begin
    pad_d_o  = func_d_i;
    pad_oe_o = func_oe_i;
    if (busy) begin
      pad_d_o = {NumPads{pat_q}};
      for (int i = 0; i < NumPads; i++) begin
        pad_oe_o[i] = (idx_q == IdxW'(i));
      end
    end
  end

  assign busy_o      = busy;
  assign pass_o      = pass_q;
  assign fail_mask_o = fail_q;

endmodule

// File: tb/tb_mc_pad_selftest.sv
// Directed bench for mc_pad_selftest: default 8-pad instance with a loopback model
// and injectable stuck-at faults, plus a 1-pad / 2-settle-cycle instance.
module tb_mc_pad_selftest;

  localparam int NP       = 8;
  localparam int SC       = 4;
  localparam int STEP     = SC + 1;
  localparam int DONE_CYC = 1 + 2 * NP * STEP;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default-parameter instance
  logic          start_a, busy_a, done_a, pass_a;
  logic [NP-1:0] mask_a, func_d, func_oe, pad_d_a, pad_oe_a, pad_di_a;
  logic [NP-1:0] stuck0, stuck1;

  assign pad_di_a = stuck1 | (~stuck0 & pad_oe_a & pad_d_a);

  mc_pad_selftest dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .fail_mask_o(mask_a),
    .func_d_i(func_d), .func_oe_i(func_oe),
    .pad_d_o(pad_d_a), .pad_oe_o(pad_oe_a), .pad_d_i(pad_di_a)
  );

  // single-pad instance
  logic start_b, busy_b, done_b, pass_b;
  logic [0:0] mask_b, func_d_b, func_oe_b, pad_d_b, pad_oe_b, pad_di_b;

  assign pad_di_b = pad_oe_b & pad_d_b;

  mc_pad_selftest #(.NumPads(1), .SettleCycles(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .fail_mask_o(mask_b),
    .func_d_i(func_d_b), .func_oe_i(func_oe_b),
    .pad_d_o(pad_d_b), .pad_oe_o(pad_oe_b), .pad_d_i(pad_di_b)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full test on dut_a. Start is driven at the current negedge (cycle 0);
  // each later negedge observes cycle c.
  task automatic run_a(input logic [NP-1:0] exp_mask, input bit hold);
    int done_cyc;
    logic [7:0] oe;
    logic [7:0] d;
    logic [15:0] e;
    for (int s = 0; s < 2 * NP; s++) begin
      oe = 8'h01 << (s / 2);
      d  = (s % 2 == 1) ? 8'hFF : 8'h00;
      exp_q.push_back({oe, d});
    end
    start_a  = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= DONE_CYC + 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (!hold) start_a = 1'b0;
      if ((c - 1) % STEP == 0 && c < DONE_CYC) begin
        if (exp_q.size() == 0) begin
          chk("walk_underflow", 32'(c), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("oe_walk", 32'(pad_oe_a), 32'(e[15:8]));
          chk("d_walk", 32'(pad_d_a), 32'(e[7:0]));
        end
      end
      if (done_a) done_cyc = c;
    end
    chk("done_cycle", 32'(done_cyc), 32'(DONE_CYC));
    chk("busy_at_done", 32'(busy_a), 32'(0));
    chk("walk_left", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse_width", 32'(done_a), 32'(0));
    chk("pass", 32'(pass_a), 32'(exp_mask == '0));
    chk("fail_mask", 32'(mask_a), 32'(exp_mask));
    chk("oe_restored", 32'(pad_oe_a), 32'(func_oe));
    chk("d_restored", 32'(pad_d_a), 32'(func_d));
    if (hold) begin
      @(negedge clk);
      chk("reaccept_busy", 32'(busy_a), 32'(1));
      chk("reaccept_mask_clr", 32'(mask_a), 32'(0));
    end
  endtask

  initial begin
    bit seen_done;
    int done_cyc;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    stuck0 = '0; stuck1 = '0;
    func_d = '0; func_oe = '0; func_d_b = '0; func_oe_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_pass", 32'(pass_a), 32'(0));
    chk("rst_mask", 32'(mask_a), 32'(0));
    chk("rst_b_busy", 32'(busy_b), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // idle passthrough, same cycle
    func_oe = 8'hA5; func_d = 8'h3C; func_oe_b = 1'b1; func_d_b = 1'b0;
    #1;
    chk("pass_oe", 32'(pad_oe_a), 32'h00A5);
    chk("pass_d", 32'(pad_d_a), 32'h003C);
    chk("pass_b_oe", 32'(pad_oe_b), 32'(1));
    func_d = 8'($urandom_range(0, 255));
    #1;
    chk("pass_d_rand", 32'(pad_d_a), 32'(func_d));
    @(negedge clk);

    // ideal loopback, then stuck-at faults
    run_a(8'h00, 1'b0);
    stuck0 = 8'h08;
    run_a(8'h08, 1'b0);
    stuck1 = 8'h20;
    run_a(8'h28, 1'b0);

    // start held high: back-to-back acceptance
    stuck1 = 8'h00;
    run_a(8'h08, 1'b1);
    start_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'(0));

    // reset mid-test at cycle 40
    stuck0 = 8'h00; stuck1 = 8'h08;
    start_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 39) chk("pre_rst_mask", 32'(mask_a), 32'h0008);
    end
    chk("pre_rst_busy", 32'(busy_a), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy_a), 32'(0));
    chk("midrst_mask", 32'(mask_a), 32'(0));
    chk("midrst_pass", 32'(pass_a), 32'(0));
    chk("midrst_oe", 32'(pad_oe_a), 32'(func_oe));
    chk("midrst_d", 32'(pad_d_a), 32'(func_d));
    seen_done = done_a;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    chk("midrst_no_done", 32'(seen_done), 32'(0));
    stuck1 = '0;

    // NumPads=1, SettleCycles=2
    start_b  = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (c == 1) begin
        chk("b_oe", 32'(pad_oe_b), 32'(1));
        chk("b_d", 32'(pad_d_b), 32'(0));
      end
      if (done_b) done_cyc = c;
    end
    chk("b_done_cycle", 32'(done_cyc), 32'(7));
    @(negedge clk);
    chk("b_pass", 32'(pass_b), 32'(1));
    chk("b_mask", 32'(mask_b), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
